// File: rtl/para_rd_ctrl.sv
// para_rd_ctrl: read sequencer for the 5-row weight/bias parameter ROM bank.
// Walks the weight-column addresses of one output kernel at a time and
// delays a valid/column-index strobe by the ROM read latency. It then waits
// for the MAC to finish the feature map before moving to the next kernel.

module para_rd_ctrl #(
  parameter int unsigned KERNEL_NUM = 6,
  parameter int unsigned IN_CH      = 1,
  parameter int unsigned KSIZE      = 5,
  parameter int unsigned ROM_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       conv_done_i,
  output logic [7:0] param_rd_addr_o,
  output logic [4:0] conv_cnt_o,
  output logic       w_valid_o,
  output logic [7:0] w_col_o,
  output logic       kernel_ready_o,
  output logic       busy_o,
  output logic       layer_done_o
);

  localparam int unsigned NCOL        = KSIZE * IN_CH;
  localparam logic [7:0]  LAST_COL    = 8'(NCOL - 1);
  localparam logic [4:0]  LAST_KERNEL = 5'(KERNEL_NUM - 1);
  localparam logic [2:0]  LAST_DRAIN  = 3'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    DRAIN     = 2'd2,
    WAIT_CONV = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [4:0] kernel_q, kernel_d;
  logic [7:0] col_q, col_d;
  logic [2:0] drain_q, drain_d;
  logic       kready_q, kready_d;
  logic       ldone_q, ldone_d;
  logic       busy_q, busy_d;
  logic       issue;

  logic       valid_pipe_q [ROM_LAT];
  logic [7:0] col_pipe_q   [ROM_LAT];

  // An address goes out to the ROMs on every LOAD cycle.
  assign issue = (state_q == LOAD);

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    kernel_d = kernel_q;
    col_d    = col_q;
    drain_d  = drain_q;
    kready_d = 1'b0;
    ldone_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = LOAD;
          addr_d   = 8'd0;
          kernel_d = 5'd0;
          col_d    = 8'd0;
        end
      end
      LOAD: begin
        if (col_q == LAST_COL) begin
          state_d = DRAIN;
          drain_d = 3'd0;
        end else begin
          addr_d = addr_q + 8'd1;
          col_d  = col_q + 8'd1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d  = WAIT_CONV;
          kready_d = 1'b1;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      WAIT_CONV: begin
        if (conv_done_i) begin
          if (kernel_q == LAST_KERNEL) begin
            state_d  = IDLE;
            ldone_d  = 1'b1;
            kernel_d = 5'd0;
            addr_d   = 8'd0;
          end else begin
            state_d  = LOAD;
            kernel_d = kernel_q + 5'd1;
            addr_d   = addr_q + 8'd1;
            col_d    = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Sequencer state and its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 8'd0;
      kernel_q <= 5'd0;
      col_q    <= 8'd0;
      drain_q  <= 3'd0;
      kready_q <= 1'b0;
      ldone_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      kernel_q <= kernel_d;
      col_q    <= col_d;
      drain_q  <= drain_d;
      kready_q <= kready_d;
      ldone_q  <= ldone_d;
      busy_q   <= busy_d;
    end
  end

  // Latency-matching shift pipeline carrying valid and column index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ROM_LAT); i++) begin
        valid_pipe_q[i] <= 1'b0;
        col_pipe_q[i]   <= 8'd0;
      end
    end else begin
      valid_pipe_q[0] <= issue;
      col_pipe_q[0]   <= issue ? col_q : 8'd0;
      for (int i = 1; i < int'(ROM_LAT); i++) begin
        valid_pipe_q[i] <= valid_pipe_q[i-1];
        col_pipe_q[i]   <= col_pipe_q[i-1];
      end
    end
  end

  assign param_rd_addr_o = addr_q;
  assign conv_cnt_o      = kernel_q;
  assign w_valid_o       = valid_pipe_q[ROM_LAT-1];
  assign w_col_o         = col_pipe_q[ROM_LAT-1];
  assign kernel_ready_o  = kready_q;
  assign busy_o          = busy_q;
  assign layer_done_o    = ldone_q;

endmodule

// File: tb/tb_para_rd_ctrl.sv
// Testbench for para_rd_ctrl: instance A runs two kernels of one channel with
// ROM latency 1, instance B runs one kernel of three channels with latency 2.
// Expected per-cycle outputs come from hand-derived cycle tables.

module tb_para_rd_ctrl;

  logic       clk;
  logic       rstA_n, startA, doneA;
  logic [7:0] addrA, wcolA;
  logic [4:0] cntA;
  logic       wvA, krA, busyA, ldA;
  logic       rstB_n, startB, doneB;
  logic [7:0] addrB, wcolB;
  logic [4:0] cntB;
  logic       wvB, krB, busyB, ldB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic [4:0] cnt;
    logic       wv;
    logic [7:0] wcol;
    logic       kr;
    logic       busy;
    logic       ld;
  } exp_t;

  para_rd_ctrl #(.KERNEL_NUM(2), .IN_CH(1), .KSIZE(5), .ROM_LAT(1)) dutA (
    .clk(clk), .rst_n(rstA_n), .start_i(startA), .conv_done_i(doneA),
    .param_rd_addr_o(addrA), .conv_cnt_o(cntA), .w_valid_o(wvA), .w_col_o(wcolA),
    .kernel_ready_o(krA), .busy_o(busyA), .layer_done_o(ldA)
  );

  para_rd_ctrl #(.KERNEL_NUM(1), .IN_CH(3), .KSIZE(5), .ROM_LAT(2)) dutB (
    .clk(clk), .rst_n(rstB_n), .start_i(startB), .conv_done_i(doneB),
    .param_rd_addr_o(addrB), .conv_cnt_o(cntB), .w_valid_o(wvB), .w_col_o(wcolB),
    .kernel_ready_o(krB), .busy_o(busyB), .layer_done_o(ldB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A, start in cycle 0, conv_done in cycles 10 and 20.
  function automatic exp_t expA(input int c);
    exp_t e;
    e.addr = 8'd0; e.cnt = 5'd0; e.wv = 1'b0; e.wcol = 8'd0;
    e.kr = 1'b0; e.busy = 1'b0; e.ld = 1'b0;
    if (c >= 1 && c <= 5)   e.addr = 8'(c - 1);
    if (c >= 6 && c <= 10)  e.addr = 8'd4;
    if (c >= 11 && c <= 15) e.addr = 8'(c - 6);
    if (c >= 16 && c <= 20) e.addr = 8'd9;
    if (c >= 11 && c <= 20) e.cnt = 5'd1;
    if (c >= 2 && c <= 6)   begin e.wv = 1'b1; e.wcol = 8'(c - 2);  end
    if (c >= 12 && c <= 16) begin e.wv = 1'b1; e.wcol = 8'(c - 12); end
    e.kr   = (c == 7 || c == 17);
    e.busy = (c >= 1 && c <= 20);
    e.ld   = (c == 21);
    return e;
  endfunction

  // Instance B, start in cycle 0, conv_done in cycle 20.
  function automatic exp_t expB(input int c);
    exp_t e;
    e.addr = 8'd0; e.cnt = 5'd0; e.wv = 1'b0; e.wcol = 8'd0;
    e.kr = 1'b0; e.busy = 1'b0; e.ld = 1'b0;
    if (c >= 1 && c <= 15)  e.addr = 8'(c - 1);
    if (c >= 16 && c <= 20) e.addr = 8'd14;
    if (c >= 3 && c <= 17)  begin e.wv = 1'b1; e.wcol = 8'(c - 3); end
    e.kr   = (c == 18);
    e.busy = (c >= 1 && c <= 20);
    e.ld   = (c == 21);
    return e;
  endfunction

  task automatic test_reset;
    rstA_n = 1'b0; rstB_n = 1'b0;
    startA = 1'b0; doneA = 1'b0; startB = 1'b0; doneB = 1'b0;
    #1;
    checks += 2;
    if ({addrA, cntA, wvA, wcolA, krA, busyA, ldA} !== 27'd0) begin
      errors++;
      $display("FAIL reset_A outputs got %h required 0", {addrA, cntA, wvA, wcolA, krA, busyA, ldA});
    end
    if ({addrB, cntB, wvB, wcolB, krB, busyB, ldB} !== 27'd0) begin
      errors++;
      $display("FAIL reset_B outputs got %h required 0", {addrB, cntB, wvB, wcolB, krB, busyB, ldB});
    end
    repeat (2) @(negedge clk);
    rstA_n = 1'b1; rstB_n = 1'b1;
  endtask

  // Runs instance A through its cycle table; noisy adds ignorable inputs.
  task automatic runA(input string tag, input bit noisy, input int lastCyc);
    exp_t e;
    for (int c = 0; c <= lastCyc; c++) begin
      @(posedge clk); #1;
      startA = (c == 0) || (noisy && (c == 2 || c == 3 || c == 8 || c == 13));
      doneA  = (c == 10) || (c == 20) || (noisy && (c == 0 || c == 3 || c == 6 || c == 14 || c == 16));
      @(negedge clk);
      e = expA(c);
      checks += 6;
      if (addrA !== e.addr) begin errors++; $display("FAIL %s addr cycle %0d got %0d required %0d", tag, c, addrA, e.addr); end
      if (cntA !== e.cnt) begin errors++; $display("FAIL %s conv_cnt cycle %0d got %0d required %0d", tag, c, cntA, e.cnt); end
      if (wvA !== e.wv) begin errors++; $display("FAIL %s w_valid cycle %0d got %b required %b", tag, c, wvA, e.wv); end
      if (krA !== e.kr) begin errors++; $display("FAIL %s kernel_ready cycle %0d got %b required %b", tag, c, krA, e.kr); end
      if (busyA !== e.busy) begin errors++; $display("FAIL %s busy cycle %0d got %b required %b", tag, c, busyA, e.busy); end
      if (ldA !== e.ld) begin errors++; $display("FAIL %s layer_done cycle %0d got %b required %b", tag, c, ldA, e.ld); end
      if (e.wv) begin
        checks++;
        if (wcolA !== e.wcol) begin errors++; $display("FAIL %s w_col cycle %0d got %0d required %0d", tag, c, wcolA, e.wcol); end
      end
    end
    startA = 1'b0; doneA = 1'b0;
  endtask

  task automatic test_two_kernel;
    runA("two_kernel", 1'b0, 24);
  endtask

  task automatic test_ignored_inputs;
    runA("ignored_inputs", 1'b1, 24);
  endtask

  task automatic test_multi_channel;
    exp_t e;
    for (int c = 0; c <= 24; c++) begin
      @(posedge clk); #1;
      startB = (c == 0);
      doneB  = (c == 20);
      @(negedge clk);
      e = expB(c);
      checks += 6;
      if (addrB !== e.addr) begin errors++; $display("FAIL multi_channel addr cycle %0d got %0d required %0d", c, addrB, e.addr); end
      if (cntB !== e.cnt) begin errors++; $display("FAIL multi_channel conv_cnt cycle %0d got %0d required %0d", c, cntB, e.cnt); end
      if (wvB !== e.wv) begin errors++; $display("FAIL multi_channel w_valid cycle %0d got %b required %b", c, wvB, e.wv); end
      if (krB !== e.kr) begin errors++; $display("FAIL multi_channel kernel_ready cycle %0d got %b required %b", c, krB, e.kr); end
      if (busyB !== e.busy) begin errors++; $display("FAIL multi_channel busy cycle %0d got %b required %b", c, busyB, e.busy); end
      if (ldB !== e.ld) begin errors++; $display("FAIL multi_channel layer_done cycle %0d got %b required %b", c, ldB, e.ld); end
      if (e.wv) begin
        checks++;
        if (wcolB !== e.wcol) begin errors++; $display("FAIL multi_channel w_col cycle %0d got %0d required %0d", c, wcolB, e.wcol); end
      end
    end
    startB = 1'b0; doneB = 1'b0;
  endtask

  task automatic test_mid_reset;
    runA("mid_reset_pre", 1'b0, 12);
    @(posedge clk); #2;
    checks++;
    if (addrA !== 8'd7) begin errors++; $display("FAIL mid_reset pre_addr got %0d required 7", addrA); end
    rstA_n = 1'b0;
    #1;
    checks++;
    if ({addrA, cntA, wvA, wcolA, krA, busyA, ldA} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset async_clear got %h required 0", {addrA, cntA, wvA, wcolA, krA, busyA, ldA});
    end
    @(negedge clk);
    rstA_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 2;
      if (ldA !== 1'b0) begin errors++; $display("FAIL mid_reset no_done got %b required 0", ldA); end
      if (busyA !== 1'b0) begin errors++; $display("FAIL mid_reset idle_busy got %b required 0", busyA); end
    end
    @(posedge clk); #1 startA = 1'b1;
    @(posedge clk); #1 startA = 1'b0;
    @(negedge clk);
    checks += 3;
    if (addrA !== 8'd0) begin errors++; $display("FAIL mid_reset restart_addr got %0d required 0", addrA); end
    if (cntA !== 5'd0) begin errors++; $display("FAIL mid_reset restart_cnt got %0d required 0", cntA); end
    if (busyA !== 1'b1) begin errors++; $display("FAIL mid_reset restart_busy got %b required 1", busyA); end
    @(negedge clk);
    checks += 2;
    if (addrA !== 8'd1) begin errors++; $display("FAIL mid_reset second_addr got %0d required 1", addrA); end
    if (wvA !== 1'b1 || wcolA !== 8'd0) begin errors++; $display("FAIL mid_reset first_valid got %b/%0d required 1/0", wvA, wcolA); end
  endtask

  initial begin
    test_reset();
    test_two_kernel();
    test_multi_channel();
    test_ignored_inputs();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
